// File: rtl/ks_pkg.sv
// Shared constants and FSM encoding for the byte-serial Kogge-Stone adder.
package ks_pkg;

  localparam int unsigned KS_BYTE_W     = 8;
  localparam int unsigned KS_MAX_NBYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ks_ser_state_t;

endpackage

// File: rtl/kogge_stone.sv
// 8-bit Kogge-Stone prefix adder: s = a + b + cin (9 bits), c[i] = carry out of bit i.
module kogge_stone (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [8:0] s,
  output logic [7:0] c
);

  logic [7:0] g0, p0, g1, p1, g2, p2, g3;

  always_comb begin
    p0 = a ^ b;
    g0 = a & b;
    // Folding cin into bit 0's generate makes every prefix carry include it.
    g0[0] = (a[0] & b[0]) | (p0[0] & cin);

    g1 = g0;
    p1 = p0;
    for (int unsigned i = 1; i < 8; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
      p1[i] = p0[i] & p0[i-1];
    end

    g2 = g1;
    p2 = p1;
    for (int unsigned i = 2; i < 8; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
      p2[i] = p1[i] & p1[i-2];
    end

    g3 = g2;
    for (int unsigned i = 4; i < 8; i++) begin
      g3[i] = g2[i] | (p2[i] & g2[i-4]);
    end

    c    = g3;
    s[0] = p0[0] ^ cin;
    for (int unsigned i = 1; i < 8; i++) begin
      s[i] = p0[i] ^ g3[i-1];
    end
    s[8] = g3[7];
  end

endmodule

// File: rtl/ks_serial_adder.sv
// Wide adder built by streaming operands byte-serially (LSB first) through one
// 8-bit Kogge-Stone stage, with the inter-byte carry held in a flop.
module ks_serial_adder
  import ks_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [KS_BYTE_W*NBYTES-1:0] a,
  input  logic [KS_BYTE_W*NBYTES-1:0] b,
  input  logic                       cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [KS_BYTE_W*NBYTES-1:0] sum,
  output logic                       cout,
  output logic                       busy
);

  localparam int unsigned W     = KS_BYTE_W * NBYTES;
  localparam int unsigned CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  ks_ser_state_t state, state_next;

  logic [W-1:0]     a_sh, b_sh, sum_sh, sum_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last_byte;
  logic [8:0]       byte_s;
  logic [7:0]       c_unused;

  kogge_stone u_ks (
    .a   (a_sh[7:0]),
    .b   (b_sh[7:0]),
    .cin (carry),
    .s   (byte_s),
    .c   (c_unused)
  );

  assign last_byte = (cnt == CNT_W'(NBYTES - 1));

  generate
    if (NBYTES == 1) begin : g_single
      assign sum_next = byte_s[7:0];
    end else begin : g_multi
      assign sum_next = {byte_s[7:0], sum_sh[W-1:8]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_byte) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_sh   <= a;
          b_sh   <= b;
          carry  <= cin;
          sum_sh <= '0;
          cnt    <= '0;
        end
        RUN: begin
          a_sh   <= a_sh >> KS_BYTE_W;
          b_sh   <= b_sh >> KS_BYTE_W;
          sum_sh <= sum_next;
          carry  <= byte_s[8];
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    sum       = sum_sh;
    cout      = carry;
  end

endmodule

// File: tb/tb_ks_serial_adder.sv
// Scoreboard bench for ks_serial_adder: NBYTES=4 main instance plus an NBYTES=1 instance.
module tb_ks_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [31:0] a, b, sum;

  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [7:0]  a1, b1, sum1;

  ks_serial_adder #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  ks_serial_adder #(.NBYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  int compared = 0;
  int mismatched = 0;
  int unsigned cyc = 0;

  logic [32:0] exp_q[$];
  logic [8:0]  exp1_q[$];
  int unsigned acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitors: compare whenever a result is handed over.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result4", {31'd0, cout, sum}, 64'h1_DEAD_BEEF);
      else chk("result4", {31'd0, cout, sum}, {31'd0, exp_q.pop_front()});
    end
    if (rst_n && out_valid1 && out_ready1) begin
      if (exp1_q.size() == 0) chk("unexpected_result1", {55'd0, cout1, sum1}, 64'h1FF_FFFF);
      else chk("result1", {55'd0, cout1, sum1}, {55'd0, exp1_q.pop_front()});
    end
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc + 1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic ic,
                       input logic push, input logic [32:0] expv);
    int unsigned n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    if (push) exp_q.push_back(expv);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int unsigned n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_busy", busy, 0);
    step(); step();
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    // Case 1: latency exactly 4 edges after accept.
    issue(32'h41, 32'h54, 1'b0, 1'b1, {1'b0, 32'h95});
    chk("run_busy", busy, 1);
    chk("run_in_ready", in_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("latency_edge%0d", i), out_valid, (i == 4));
    end
    step();

    // Case 2: carry rippling through every byte.
    issue(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, {1'b1, 32'h0});
    wait_out();
    step();

    // Case 4: consumer stalls; new operands offered meanwhile must be ignored.
    out_ready = 1'b0;
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, {1'b0, 32'h2345_6789});
    wait_out();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
      step();
      chk("hold_sum", sum, 32'h2345_6789);
      chk("hold_cout", cout, 0);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);

    // Case 3: back-to-back with in_valid held high.
    acc_q.delete();
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
    exp_q.push_back({1'b0, 32'h2345_6789});
    step();
    a = 32'h8000_0000; b = 32'h8000_0000;
    exp_q.push_back({1'b1, 32'h0});
    for (int i = 0; i < 20 && acc_q.size() < 2; i++) step();
    in_valid = 1'b0;
    if (acc_q.size() < 2) chk("b2b_accept_timeout", acc_q.size(), 2);
    else chk("b2b_spacing", acc_q[1] - acc_q[0], 6);
    wait_out();
    step();

    // Case 5: reset during the second RUN cycle discards the operation.
    issue(32'hCDAB_2B1C, 32'hAB90_5B90, 1'b0, 1'b0, '0);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_busy", busy, 0);
    step();
    rst_n = 1'b1;
    chk("postrst_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("postrst_no_output", out_valid, 0);
    end
    issue(32'hFF, 32'h1, 1'b0, 1'b1, {1'b0, 32'h100});
    wait_out();
    step();

    // Case 6: NBYTES=1 single-cycle RUN.
    a1 = 8'hCD; b1 = 8'hAB; cin1 = 1'b0; in_valid1 = 1'b1;
    exp1_q.push_back({1'b1, 8'h78});
    step();
    in_valid1 = 1'b0;
    chk("nb1_not_yet", out_valid1, 0);
    step();
    chk("nb1_latency", out_valid1, 1);
    step();
    chk("nb1_back_idle", in_ready1, 1);

    step(); step();
    chk("scoreboard_drained4", exp_q.size(), 0);
    chk("scoreboard_drained1", exp1_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
